// File: rtl/cpu_branch_tracker.sv
// rtl/cpu_branch_tracker.sv - in-order FIFO of in-flight branch predictions between fetch and execute
//
// Ports:
//   clk, rst_n        clock; synchronous active-low reset
//   push_valid        fetch records a branch {push_pc, push_pred_taken, push_pred_target}
//   push_ready        FIFO not full (depends on state only, never on a same-cycle resolve)
//   resolve_valid     execute resolved the oldest branch: resolve_taken, resolve_target
//   ext_flush         trap/exception kill: clear FIFO, drop push, discard resolve
//   update            one-cycle pulse to predictor with update_addr/update_taken
//   flush             one-cycle mispredict pulse with redirect_pc
//   resolve_err       one-cycle pulse: resolve arrived while FIFO empty
//   count             current occupancy 0..DEPTH
module cpu_branch_tracker #(
  parameter int XLEN        = 32,
  parameter int DEPTH_WIDTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_valid,
  output logic                   push_ready,
  input  logic [XLEN-1:0]        push_pc,
  input  logic                   push_pred_taken,
  input  logic [XLEN-1:0]        push_pred_target,
  input  logic                   resolve_valid,
  input  logic                   resolve_taken,
  input  logic [XLEN-1:0]        resolve_target,
  input  logic                   ext_flush,
  output logic                   update,
  output logic [XLEN-1:0]        update_addr,
  output logic                   update_taken,
  output logic                   flush,
  output logic [XLEN-1:0]        redirect_pc,
  output logic                   resolve_err,
  output logic [DEPTH_WIDTH:0]   count
);

  localparam int DEPTH = 1 << DEPTH_WIDTH;

  logic [XLEN-1:0]        pc_mem     [DEPTH];
  logic                   taken_mem  [DEPTH];
  logic [XLEN-1:0]        target_mem [DEPTH];

  logic [DEPTH_WIDTH-1:0] wr_ptr;
  logic [DEPTH_WIDTH-1:0] rd_ptr;
  logic [DEPTH_WIDTH:0]   cnt;

  logic                   full;
  logic                   empty;
  logic [XLEN-1:0]        head_pc;
  logic                   head_taken;
  logic [XLEN-1:0]        head_target;
  logic                   resolve_fire;
  logic                   mispredict;
  logic                   kill;
  logic                   push_accept;
  logic [DEPTH_WIDTH:0]   inc;
  logic [DEPTH_WIDTH:0]   dec;

  assign full        = (cnt == (DEPTH_WIDTH+1)'(DEPTH));
  assign empty       = (cnt == '0);
  assign push_ready  = !full;
  assign count       = cnt;

  assign head_pc     = pc_mem[rd_ptr];
  assign head_taken  = taken_mem[rd_ptr];
  assign head_target = target_mem[rd_ptr];

  assign resolve_fire = resolve_valid && !empty;
  assign mispredict   = (head_taken != resolve_taken) ||
                        (resolve_taken && (head_target != resolve_target));

  // Either kill source empties the FIFO; any push in that cycle is wrong-path.
  assign kill        = ext_flush || (resolve_fire && mispredict);
  assign push_accept = push_valid && push_ready && !kill;

  assign inc = {{DEPTH_WIDTH{1'b0}}, push_accept};
  assign dec = {{DEPTH_WIDTH{1'b0}}, resolve_fire};

  // Entry storage carries no reset; only pointers/count define validity.
  always_ff @(posedge clk) begin
    if (rst_n && push_accept) begin
      pc_mem[wr_ptr]     <= push_pc;
      taken_mem[wr_ptr]  <= push_pred_taken;
      target_mem[wr_ptr] <= push_pred_target;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      cnt          <= '0;
      update       <= 1'b0;
      update_addr  <= '0;
      update_taken <= 1'b0;
      flush        <= 1'b0;
      redirect_pc  <= '0;
      resolve_err  <= 1'b0;
    end else begin
      update      <= 1'b0;
      flush       <= 1'b0;
      resolve_err <= 1'b0;
      if (ext_flush) begin
        // Trap kill: the resolve in this cycle belongs to a dead instruction stream.
        rd_ptr <= wr_ptr;
        cnt    <= '0;
      end else if (resolve_fire && mispredict) begin
        update       <= 1'b1;
        update_addr  <= head_pc;
        update_taken <= resolve_taken;
        flush        <= 1'b1;
        redirect_pc  <= resolve_taken ? resolve_target : head_pc + XLEN'(4);
        rd_ptr       <= wr_ptr;
        cnt          <= '0;
      end else begin
        if (push_accept) begin
          wr_ptr <= wr_ptr + 1'b1;
        end
        if (resolve_fire) begin
          update       <= 1'b1;
          update_addr  <= head_pc;
          update_taken <= resolve_taken;
          rd_ptr       <= rd_ptr + 1'b1;
        end
        if (resolve_valid && empty) begin
          resolve_err <= 1'b1;
        end
        cnt <= cnt + inc - dec;
      end
    end
  end

endmodule

// File: tb/tb_cpu_branch_tracker.sv
// tb/tb_cpu_branch_tracker.sv - directed self-checking bench for cpu_branch_tracker
module tb_cpu_branch_tracker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        push_valid;
  logic        push_ready;
  logic [31:0] push_pc;
  logic        push_pred_taken;
  logic [31:0] push_pred_target;
  logic        resolve_valid;
  logic        resolve_taken;
  logic [31:0] resolve_target;
  logic        ext_flush;
  logic        update;
  logic [31:0] update_addr;
  logic        update_taken;
  logic        flush;
  logic [31:0] redirect_pc;
  logic        resolve_err;
  logic [2:0]  count;

  int pass_cnt = 0;
  int total    = 0;

  cpu_branch_tracker #(.XLEN(32), .DEPTH_WIDTH(2)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .push_valid       (push_valid),
    .push_ready       (push_ready),
    .push_pc          (push_pc),
    .push_pred_taken  (push_pred_taken),
    .push_pred_target (push_pred_target),
    .resolve_valid    (resolve_valid),
    .resolve_taken    (resolve_taken),
    .resolve_target   (resolve_target),
    .ext_flush        (ext_flush),
    .update           (update),
    .update_addr      (update_addr),
    .update_taken     (update_taken),
    .flush            (flush),
    .redirect_pc      (redirect_pc),
    .resolve_err      (resolve_err),
    .count            (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic idle_inputs();
    push_valid       = 1'b0;
    push_pc          = '0;
    push_pred_taken  = 1'b0;
    push_pred_target = '0;
    resolve_valid    = 1'b0;
    resolve_taken    = 1'b0;
    resolve_target   = '0;
    ext_flush        = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic set_push(input logic [31:0] pc, input logic pt, input logic [31:0] tgt);
    push_valid       = 1'b1;
    push_pc          = pc;
    push_pred_taken  = pt;
    push_pred_target = tgt;
  endtask

  task automatic set_resolve(input logic t, input logic [31:0] tgt);
    resolve_valid  = 1'b1;
    resolve_taken  = t;
    resolve_target = tgt;
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;

    check("rst_count", 32'(count), 32'd0);
    check("rst_push_ready", 32'(push_ready), 32'd1);
    check("rst_update", 32'(update), 32'd0);
    check("rst_update_addr", update_addr, 32'd0);
    check("rst_flush", 32'(flush), 32'd0);
    check("rst_redirect", redirect_pc, 32'd0);
    check("rst_resolve_err", 32'(resolve_err), 32'd0);

    // Correct not-taken prediction
    set_push(32'h100, 1'b0, 32'h0);
    step();
    check("s1_count_after_push", 32'(count), 32'd1);
    set_resolve(1'b0, 32'h0);
    step();
    check("s1_update", 32'(update), 32'd1);
    check("s1_update_addr", update_addr, 32'h100);
    check("s1_update_taken", 32'(update_taken), 32'd0);
    check("s1_flush", 32'(flush), 32'd0);
    check("s1_count", 32'(count), 32'd0);
    step();
    check("s1_update_pulse_end", 32'(update), 32'd0);

    // Predicted not-taken, actually taken
    set_push(32'h200, 1'b0, 32'h0);
    step();
    set_resolve(1'b1, 32'h300);
    step();
    check("s2_update", 32'(update), 32'd1);
    check("s2_update_taken", 32'(update_taken), 32'd1);
    check("s2_flush", 32'(flush), 32'd1);
    check("s2_redirect", redirect_pc, 32'h300);
    check("s2_count", 32'(count), 32'd0);
    step();
    check("s2_flush_pulse_end", 32'(flush), 32'd0);

    // Predicted taken, wrong target
    set_push(32'h400, 1'b1, 32'h480);
    step();
    set_resolve(1'b1, 32'h500);
    step();
    check("s3a_flush", 32'(flush), 32'd1);
    check("s3a_redirect", redirect_pc, 32'h500);

    // Predicted taken, actually not taken
    set_push(32'h400, 1'b1, 32'h480);
    step();
    set_resolve(1'b0, 32'h0);
    step();
    check("s3b_flush", 32'(flush), 32'd1);
    check("s3b_redirect", redirect_pc, 32'h404);
    check("s3b_update_addr", update_addr, 32'h400);

    // Predicted taken, correct target
    set_push(32'h400, 1'b1, 32'h480);
    step();
    set_resolve(1'b1, 32'h480);
    step();
    check("s3c_flush", 32'(flush), 32'd0);
    check("s3c_update", 32'(update), 32'd1);
    check("s3c_count", 32'(count), 32'd0);

    // Fill to full; fifth push ignored
    set_push(32'h10, 1'b0, 32'h0); step();
    set_push(32'h14, 1'b0, 32'h0); step();
    set_push(32'h18, 1'b0, 32'h0); step();
    set_push(32'h1C, 1'b0, 32'h0); step();
    check("s4_full_count", 32'(count), 32'd4);
    check("s4_full_ready", 32'(push_ready), 32'd0);
    set_push(32'h24, 1'b0, 32'h0);
    step();
    check("s4_fifth_ignored", 32'(count), 32'd4);

    // Resolve while full: push_ready stays low, so the push is refused
    set_resolve(1'b0, 32'h0);
    set_push(32'h20, 1'b0, 32'h0);
    step();
    check("s4_full_resolve_addr", update_addr, 32'h10);
    check("s4_full_resolve_count", 32'(count), 32'd3);
    set_push(32'h20, 1'b0, 32'h0);
    step();
    check("s4_refill_count", 32'(count), 32'd4);

    // Back-to-back drain
    set_resolve(1'b0, 32'h0); step();
    check("s4_drain0_update", 32'(update), 32'd1);
    check("s4_drain0_addr", update_addr, 32'h14);
    set_resolve(1'b0, 32'h0); step();
    check("s4_drain1_update", 32'(update), 32'd1);
    check("s4_drain1_addr", update_addr, 32'h18);
    set_resolve(1'b0, 32'h0); step();
    check("s4_drain2_update", 32'(update), 32'd1);
    check("s4_drain2_addr", update_addr, 32'h1C);
    set_resolve(1'b0, 32'h0); step();
    check("s4_drain3_update", 32'(update), 32'd1);
    check("s4_drain3_addr", update_addr, 32'h20);
    check("s4_drain_count", 32'(count), 32'd0);
    check("s4_drain_flush", 32'(flush), 32'd0);

    // Three queued; resolve + push nets unchanged count
    set_push(32'h30, 1'b0, 32'h0); step();
    set_push(32'h34, 1'b0, 32'h0); step();
    set_push(32'h38, 1'b0, 32'h0); step();
    set_resolve(1'b0, 32'h0);
    set_push(32'h3C, 1'b0, 32'h0);
    step();
    check("s5_net_count", 32'(count), 32'd3);
    check("s5_net_addr", update_addr, 32'h30);

    // Mispredict with same-cycle push: everything dropped
    set_resolve(1'b1, 32'h90);
    set_push(32'h40, 1'b0, 32'h0);
    step();
    check("s5_misp_count", 32'(count), 32'd0);
    check("s5_misp_flush", 32'(flush), 32'd1);
    check("s5_misp_redirect", redirect_pc, 32'h90);
    check("s5_misp_addr", update_addr, 32'h34);
    set_resolve(1'b0, 32'h0);
    step();
    check("s5_empty_err", 32'(resolve_err), 32'd1);
    check("s5_empty_update", 32'(update), 32'd0);
    check("s5_empty_flush", 32'(flush), 32'd0);
    check("s5_empty_count", 32'(count), 32'd0);

    // Empty resolve with a push: push proceeds
    set_resolve(1'b0, 32'h0);
    set_push(32'h50, 1'b0, 32'h0);
    step();
    check("s5_err_push_err", 32'(resolve_err), 32'd1);
    check("s5_err_push_count", 32'(count), 32'd1);
    set_resolve(1'b0, 32'h0);
    step();
    check("s5_err_pulse_end", 32'(resolve_err), 32'd0);
    check("s5_after_err_addr", update_addr, 32'h50);
    check("s5_after_err_count", 32'(count), 32'd0);

    // ext_flush with a mispredicting resolve and a push in the same cycle
    set_push(32'h70, 1'b0, 32'h0); step();
    set_push(32'h74, 1'b0, 32'h0); step();
    check("s6_queued", 32'(count), 32'd2);
    ext_flush = 1'b1;
    set_resolve(1'b1, 32'hAA);
    set_push(32'h78, 1'b0, 32'h0);
    step();
    check("s6_count", 32'(count), 32'd0);
    check("s6_flush", 32'(flush), 32'd0);
    check("s6_update", 32'(update), 32'd0);
    check("s6_err", 32'(resolve_err), 32'd0);
    check("s6_ready", 32'(push_ready), 32'd1);

    // Reset mid-drain
    set_push(32'h60, 1'b0, 32'h0); step();
    set_push(32'h64, 1'b0, 32'h0); step();
    set_resolve(1'b0, 32'h0); step();
    check("s7_pre_addr", update_addr, 32'h60);
    rst_n = 1'b0;
    set_resolve(1'b1, 32'h99);
    step();
    check("s7_rst_count", 32'(count), 32'd0);
    check("s7_rst_update", 32'(update), 32'd0);
    check("s7_rst_addr", update_addr, 32'd0);
    check("s7_rst_flush", 32'(flush), 32'd0);
    check("s7_rst_redirect", redirect_pc, 32'd0);
    check("s7_rst_err", 32'(resolve_err), 32'd0);
    rst_n = 1'b1;
    step();
    check("s7_post_ready", 32'(push_ready), 32'd1);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
